// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and data memory.
// master: mem_req/mem_we/mem_addr/mem_wdata out, mem_ready/mem_rdata in.
interface mem_access_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one registered request
// per load/store, stalls the pipeline until mem_ready or timeout.
// Ports: clk, rst (async active-low), memtoreg_mem/memwrite_mem/
// aluout_mem/writedata_mem from EX/MEM, mem (bus master), stall,
// rdata_wb/rdata_valid to MEM/WB, timeout_err (sticky).
module mem_access_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memtoreg_mem,
  input  logic              memwrite_mem,
  input  logic [WIDTH-1:0]  aluout_mem,
  input  logic [WIDTH-1:0]  writedata_mem,
  mem_access_ctrl_if.master mem,
  output logic              stall,
  output logic [WIDTH-1:0]  rdata_wb,
  output logic              rdata_valid,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       is_load;
  logic       pending;

  assign pending = memtoreg_mem | memwrite_mem;

  // DONE releases the pipeline so the finished access leaves EX/MEM;
  // it is still visible there during DONE and must not be re-issued.
  assign stall = (state == BUSY) ||
                 (state == IDLE && pending);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      is_load       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rdata_wb      <= '0;
      rdata_valid   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            state         <= BUSY;
            cnt           <= '0;
            // store wins when both flags are set
            is_load       <= ~memwrite_mem;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= memwrite_mem;
            mem.mem_addr  <= aluout_mem;
            mem.mem_wdata <= writedata_mem;
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            if (is_load) begin
              rdata_wb    <= mem.mem_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (cnt == LAST) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            timeout_err <= 1'b1;
            if (is_load) begin
              rdata_wb    <= '0;
              rdata_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state       <= IDLE;
          rdata_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected
// requests and load data, a monitor pops and compares them.
module tb_mem_access_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  logic        clk;
  logic        rst;
  logic        memtoreg_mem;
  logic        memwrite_mem;
  logic [31:0] aluout_mem;
  logic [31:0] writedata_mem;
  logic        stall;
  logic [31:0] rdata_wb;
  logic        rdata_valid;
  logic        timeout_err;

  int total;
  int bad;

  req_t        req_q[$];
  logic [31:0] rd_q[$];

  mem_access_ctrl_if #(.WIDTH(32)) mem ();

  mem_access_ctrl #(
    .WIDTH  (32),
    .TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memtoreg_mem (memtoreg_mem),
    .memwrite_mem (memwrite_mem),
    .aluout_mem   (aluout_mem),
    .writedata_mem(writedata_mem),
    .mem          (mem),
    .stall        (stall),
    .rdata_wb     (rdata_wb),
    .rdata_valid  (rdata_valid),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: each new request and each rdata_valid pulse consumes
  // exactly one expected entry
  initial begin
    logic prev_req;
    req_t e;
    logic [31:0] d;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem.mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", mem.mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = req_q.pop_front();
          chk("req_we", 32'(mem.mem_we), 32'(e.we));
          chk("req_addr", mem.mem_addr, e.addr);
          chk("req_wdata", mem.mem_wdata, e.wd);
        end
      end
      prev_req = mem.mem_req;
      if (rdata_valid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_valid", rdata_wb, 32'hFFFF_FFFF);
        end else begin
          d = rd_q.pop_front();
          chk("rdata_wb", rdata_wb, d);
        end
      end
    end
  end

  // wait_n < 0: memory never answers
  task automatic access(input logic ld,
                        input logic st,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] rd,
                        input int wait_n,
                        input int exp_stall,
                        input string tag);
    int   stalls;
    int   busy;
    logic is_ld;
    req_t r;
    is_ld = ld & ~st;
    r.we   = st;
    r.addr = a;
    r.wd   = wd;
    req_q.push_back(r);
    if (is_ld) rd_q.push_back(wait_n < 0 ? 32'h0 : rd);
    @(posedge clk);
    #1;
    memtoreg_mem  = ld;
    memwrite_mem  = st;
    aluout_mem    = a;
    writedata_mem = wd;
    stalls = 0;
    busy   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (mem.mem_req) begin
        chk({tag, "_busy_we"}, 32'(mem.mem_we), 32'(st));
        chk({tag, "_busy_addr"}, mem.mem_addr, a);
        chk({tag, "_busy_wdata"}, mem.mem_wdata, wd);
        if (busy == wait_n) begin
          mem.mem_ready = 1'b1;
          mem.mem_rdata = rd;
        end else begin
          mem.mem_ready = 1'b0;
          mem.mem_rdata = 32'hBAD0_0000 | 32'(busy);
        end
        busy++;
      end
    end
    mem.mem_ready = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_valid_in_done"}, 32'(rdata_valid), 32'(is_ld));
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    memtoreg_mem = 1'b0;
    memwrite_mem = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    memtoreg_mem  = 1'b0;
    memwrite_mem  = 1'b0;
    aluout_mem    = '0;
    writedata_mem = '0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;

    #3;
    chk("rst_req", 32'(mem.mem_req), 32'h0);
    chk("rst_addr", mem.mem_addr, 32'h0);
    chk("rst_rdata", rdata_wb, 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    #14;
    rst = 1'b1;

    // single-cycle load
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2, "ld1");
    go_idle();

    // store with 3 wait cycles; rdata_wb must keep the old load data
    access(1'b0, 1'b1, 32'h80, 32'h12345678, 32'h0, 3, 5, "st1");
    chk("st1_rdata_hold", rdata_wb, 32'hDEADBEEF);
    go_idle();

    // both flags set: treated as a store
    access(1'b1, 1'b1, 32'h84, 32'hA5A5A5A5, 32'h0, 0, 2, "ldst");

    // back-to-back loads, immediate ready
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'h11111111, 0, 2, "bb1");
    access(1'b1, 1'b0, 32'h104, 32'h0, 32'h22222222, 0, 2, "bb2");
    access(1'b1, 1'b0, 32'h108, 32'h0, 32'h33333333, 0, 2, "bb3");
    go_idle();

    // mem_ready while idle is ignored
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem.mem_ready = 1'b1;
      mem.mem_rdata = 32'hFEEDFACE;
      @(negedge clk);
      chk("idle_ready_stall", 32'(stall), 32'h0);
      chk("idle_ready_req", 32'(mem.mem_req), 32'h0);
      chk("idle_ready_rdata", rdata_wb, 32'h33333333);
    end
    mem.mem_ready = 1'b0;

    // load timeout
    access(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, -1, 16, "to");
    chk("to_err", 32'(timeout_err), 32'h1);
    go_idle();
    access(1'b1, 1'b0, 32'h204, 32'h0, 32'hCAFE0001, 1, 3, "after_to");
    chk("to_err_sticky", 32'(timeout_err), 32'h1);
    go_idle();

    // reset in the middle of BUSY
    begin
      req_t r;
      r.we   = 1'b0;
      r.addr = 32'h300;
      r.wd   = 32'h0;
      req_q.push_back(r);
      @(posedge clk);
      #1;
      memtoreg_mem = 1'b1;
      aluout_mem   = 32'h300;
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("pre_rst_req", 32'(mem.mem_req), 32'h1);
      #2;
      rst          = 1'b0;
      memtoreg_mem = 1'b0;
      #1;
      chk("async_rst_req", 32'(mem.mem_req), 32'h0);
      chk("async_rst_addr", mem.mem_addr, 32'h0);
      chk("async_rst_rdata", rdata_wb, 32'h0);
      chk("async_rst_err", 32'(timeout_err), 32'h0);
      chk("async_rst_stall", 32'(stall), 32'h0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("no_retry_req", 32'(mem.mem_req), 32'h0);
        chk("no_retry_stall", 32'(stall), 32'h0);
      end
    end

    // normal access after reset
    access(1'b1, 1'b0, 32'h400, 32'h0, 32'h55AA55AA, 1, 3, "post_rst");
    chk("post_rst_err", 32'(timeout_err), 32'h0);
    go_idle();

    repeat (3) @(negedge clk);
    chk("req_q_empty", 32'(req_q.size()), 32'h0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
